// File: rtl/aes_key_stream_ctrl.sv
// aes_key_stream_ctrl: drives key_expansion load/start/step pins and streams the
// 11 round keys of each accepted op, ascending for encrypt or descending for decrypt.
module aes_key_stream_ctrl #(
    parameter int PULSE_W   = 2,
    parameter int STEP_HIGH = 2,
    parameter int STEP_LOW  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic         op_dec,
    input  logic         op_new_key,
    input  logic [127:0] op_key,
    output logic         op_err,
    output logic [127:0] key_in,
    output logic         set_new_key,
    output logic         start_enc,
    output logic         ready_enc,
    input  logic [127:0] key_enc,
    output logic         start_dec,
    output logic         ready_dec,
    input  logic [127:0] key_dec,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         rk_last,
    output logic         busy
);
    typedef enum logic [3:0] {IDLE, LOAD, WARM_START, WARM_STEP, START, CAPTURE, EMIT, STEP, ERR} state_t;
    state_t       r_state;
    logic [7:0]   r_cnt;
    logic [3:0]   r_round;
    logic [127:0] r_key_in, r_rk_data;
    logic r_dec, r_key_loaded, r_sched_valid, r_op_ready, r_op_err, r_set_new_key;
    logic r_start_enc, r_start_dec, r_ready_enc, r_ready_dec, r_rk_valid, r_rk_last;
    logic [7:0] w_high, w_cnt_nxt;
    logic       w_pin_nxt, w_done;
    // Every pin pulse shares one counter: high for w_high cycles, then STEP_LOW low.
    assign w_high    = (r_state == STEP || r_state == WARM_STEP) ? 8'(STEP_HIGH) : 8'(PULSE_W);
    assign w_cnt_nxt = r_cnt + 8'd1;
    assign w_pin_nxt = w_cnt_nxt < w_high;
    assign w_done    = r_cnt == w_high + 8'(STEP_LOW) - 8'd1;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE; r_cnt <= '0; r_round <= '0; r_key_in <= '0; r_rk_data <= '0;
            r_dec <= 1'b0; r_key_loaded <= 1'b0; r_sched_valid <= 1'b0; r_op_ready <= 1'b0;
            r_op_err <= 1'b0; r_set_new_key <= 1'b0; r_start_enc <= 1'b0; r_start_dec <= 1'b0;
            r_ready_enc <= 1'b0; r_ready_dec <= 1'b0; r_rk_valid <= 1'b0; r_rk_last <= 1'b0;
        end else begin
            r_cnt    <= w_done ? 8'd0 : w_cnt_nxt;
            r_op_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_op_ready <= 1'b1;
                    r_cnt      <= '0;
                    if (op_valid && r_op_ready) begin
                        r_op_ready <= 1'b0;
                        r_dec      <= op_dec;
                        if (op_new_key) begin
                            r_state <= LOAD; r_key_in <= op_key; r_set_new_key <= 1'b1;
                        end else if (!r_key_loaded) begin
                            r_state <= ERR; r_op_err <= 1'b1;
                        end else if (op_dec && !r_sched_valid) begin
                            r_state <= WARM_START; r_start_enc <= 1'b1;
                        end else begin
                            r_state <= START; r_start_enc <= !op_dec; r_start_dec <= op_dec;
                            r_round <= op_dec ? 4'd10 : 4'd0;
                        end
                    end
                end
                LOAD: begin
                    r_set_new_key <= w_pin_nxt;
                    if (w_done) begin
                        r_key_loaded <= 1'b1; r_sched_valid <= 1'b0; r_start_enc <= 1'b1;
                        r_state <= r_dec ? WARM_START : START; r_round <= 4'd0;
                    end
                end
                WARM_START: begin
                    r_start_enc <= w_pin_nxt;
                    if (w_done) begin
                        r_state <= WARM_STEP; r_ready_enc <= 1'b1; r_round <= 4'd0;
                    end
                end
                // Forward pass so key_expansion holds a full schedule before decrypt.
                WARM_STEP: begin
                    r_ready_enc <= w_pin_nxt;
                    if (w_done && r_round == 4'd9) begin
                        r_sched_valid <= 1'b1; r_state <= START; r_start_dec <= 1'b1; r_round <= 4'd10;
                    end else if (w_done) begin
                        r_round <= r_round + 4'd1; r_ready_enc <= 1'b1;
                    end
                end
                START: begin
                    r_start_enc <= w_pin_nxt && !r_dec;
                    r_start_dec <= w_pin_nxt && r_dec;
                    if (w_done) r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_rk_data  <= r_dec ? key_dec : key_enc;
                    r_rk_last  <= r_dec ? r_round == 4'd0 : r_round == 4'd10;
                    r_rk_valid <= 1'b1;
                    r_state    <= EMIT;
                end
                EMIT: begin
                    r_cnt <= '0;
                    if (rk_ready) begin
                        r_rk_valid <= 1'b0;
                        if (!r_dec && r_round == 4'd10) r_sched_valid <= 1'b1;
                        if (r_rk_last) begin
                            r_state <= IDLE; r_op_ready <= 1'b1;
                        end else begin
                            r_state <= STEP; r_ready_enc <= !r_dec; r_ready_dec <= r_dec;
                            r_round <= r_dec ? r_round - 4'd1 : r_round + 4'd1;
                        end
                    end
                end
                STEP: begin
                    r_ready_enc <= w_pin_nxt && !r_dec;
                    r_ready_dec <= w_pin_nxt && r_dec;
                    if (w_done) r_state <= CAPTURE;
                end
                ERR: begin
                    r_state <= IDLE; r_op_ready <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign op_ready    = r_op_ready;
    assign op_err      = r_op_err;
    assign key_in      = r_key_in;
    assign set_new_key = r_set_new_key;
    assign start_enc   = r_start_enc;
    assign start_dec   = r_start_dec;
    assign ready_enc   = r_ready_enc;
    assign ready_dec   = r_ready_dec;
    assign rk_valid    = r_rk_valid;
    assign rk_data     = r_rk_data;
    assign rk_round    = r_round;
    assign rk_last     = r_rk_last;
    assign busy        = r_state != IDLE;
endmodule
